npu_lockstep_checker: RTL and testbench

Synthesizable, parametrised output checker for NPU bring-up and on-board regression. It drains up to NCH NPU output channels in lockstep, compares each popped vector against a golden stream, and reports pass/fail, mismatch statistics, first failure and runtime in cycles. It sits between the NPU output-load ports (`o_ld_out_rd_*`) and a golden-vector source such as an on-chip ROM or host FIFO, with an idle timeout for hung runs.

---
 rtl/npu_chk_pkg.sv | 19 +
 rtl/npu_chk_cmp.sv | 27 ++
 rtl/npu_lockstep_checker.sv | 158 +++++++++++++++
 tb/tb_npu_lockstep_checker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_chk_pkg.sv
// Shared types and default sizes for the NPU lockstep output checker.
//   chk_state_t : run state of the checker (IDLE, RUN, DONE)
//   CHK_DW      : default vector width, EW*DOTW of the NPU build
//   CHK_NCH     : default number of NPU output channels checked together
//   CHK_CNTW    : default width of every counter and count input
package npu_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_t;

  // Mirror the npu.vh defaults so the checker drops in without overrides.
  localparam int CHK_DW   = 320;
  localparam int CHK_NCH  = 2;
  localparam int CHK_CNTW = 32;

endpackage

// File: rtl/npu_chk_cmp.sv
// Masked NCH-wide equality compare of NPU output vectors against one golden
// vector. A channel is flagged bad only when it is enabled and differs.
// Ports:
//   out_data  : NCH packed vectors, channel c at [c*DW +: DW]
//   gold_data : golden vector shared by all channels
//   mask      : enabled channels
//   bad       : per-channel mismatch flags
module npu_chk_cmp
  import npu_chk_pkg::*;
#(
  parameter int DW  = CHK_DW,
  parameter int NCH = CHK_NCH
) (
  input  logic [NCH*DW-1:0] out_data,
  input  logic [DW-1:0]     gold_data,
  input  logic [NCH-1:0]    mask,
  output logic [NCH-1:0]    bad
);

  always_comb begin
    bad = '0;
    for (int c = 0; c < NCH; c++) begin
      bad[c] = mask[c] & (out_data[c*DW +: DW] != gold_data);
    end
  end

endmodule

// File: rtl/npu_lockstep_checker.sv
// Drains up to NCH NPU output channels in lockstep, compares every popped
// vector against a golden stream and reports pass/fail, mismatch statistics,
// the first failing vector and the run length in cycles. An idle-cycle limit
// ends hung runs.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i_start                     : pulse; (re)starts a run, latches config
//   i_num_out/i_ch_mask/i_timeout : run configuration (timeout 0 = off)
//   i_gold_valid/o_gold_ready/i_gold_data : golden vector stream
//   i_out_rdy/i_out_data/o_out_rd_en      : FWFT NPU output channels
//   o_busy/o_done/o_pass/o_timeout        : run status
//   o_cycles/o_mismatch_cnt/o_first_bad_idx/o_first_bad_ch : statistics
module npu_lockstep_checker
  import npu_chk_pkg::*;
#(
  parameter int DW   = CHK_DW,
  parameter int NCH  = CHK_NCH,
  parameter int CNTW = CHK_CNTW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [CNTW-1:0]   i_num_out,
  input  logic [NCH-1:0]    i_ch_mask,
  input  logic [CNTW-1:0]   i_timeout,
  input  logic              i_gold_valid,
  output logic              o_gold_ready,
  input  logic [DW-1:0]     i_gold_data,
  input  logic [NCH-1:0]    i_out_rdy,
  input  logic [NCH*DW-1:0] i_out_data,
  output logic [NCH-1:0]    o_out_rd_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [CNTW-1:0]   o_cycles,
  output logic [CNTW-1:0]   o_mismatch_cnt,
  output logic [CNTW-1:0]   o_first_bad_idx,
  output logic [NCH-1:0]    o_first_bad_ch
);

  localparam logic [CNTW-1:0] ONE = {{(CNTW-1){1'b0}}, 1'b1};

  chk_state_t      state, state_nxt;
  logic [CNTW-1:0] num_out_q, timeout_q, idx_q, idle_q, cycles_q, mism_q, fb_idx_q;
  logic [NCH-1:0]  mask_q, fb_ch_q, bad;
  logic            pass_q, to_q;
  logic            all_rdy, consume, last, to_hit;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  npu_chk_cmp #(
    .DW  (DW),
    .NCH (NCH)
  ) u_cmp (
    .out_data  (i_out_data),
    .gold_data (i_gold_data),
    .mask      (mask_q),
    .bad       (bad)
  );

  // Disabled channels count as ready; a restart pulse suppresses any pop.
  assign all_rdy = &(i_out_rdy | ~mask_q);
  assign consume = (state == ST_RUN) & i_gold_valid & all_rdy & ~i_start;
  assign last    = consume & ((idx_q + ONE) == num_out_q);
  assign to_hit  = (state == ST_RUN) & ~i_start & ~consume &
                   (timeout_q != '0) & ((idle_q + ONE) >= timeout_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_gold_ready = 1'b0;
    o_out_rd_en  = '0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_start) state_nxt = (i_num_out == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (i_start) begin
          state_nxt = (i_num_out == '0) ? ST_DONE : ST_RUN;
        end else if (consume) begin
          o_gold_ready = 1'b1;
          o_out_rd_en  = mask_q;
          if (last) state_nxt = ST_DONE;
        end else if (to_hit) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_out_q <= '0;
      timeout_q <= '0;
      mask_q    <= '0;
      idx_q     <= '0;
      idle_q    <= '0;
      cycles_q  <= '0;
      mism_q    <= '0;
      fb_idx_q  <= '0;
      fb_ch_q   <= '0;
      pass_q    <= 1'b0;
      to_q      <= 1'b0;
    end else if (i_start) begin
      num_out_q <= i_num_out;
      timeout_q <= i_timeout;
      mask_q    <= i_ch_mask;
      idx_q     <= '0;
      idle_q    <= '0;
      cycles_q  <= '0;
      mism_q    <= '0;
      fb_idx_q  <= '0;
      fb_ch_q   <= '0;
      // An empty run completes immediately and trivially passes.
      pass_q    <= (i_num_out == '0);
      to_q      <= 1'b0;
    end else if (state == ST_RUN) begin
      cycles_q <= cycles_q + ONE;
      if (consume) begin
        idx_q  <= idx_q + ONE;
        idle_q <= '0;
        if (|bad) begin
          mism_q <= sat_inc(mism_q);
          // Saturation never returns to zero, so zero means no failure yet.
          if (mism_q == '0) begin
            fb_idx_q <= idx_q;
            fb_ch_q  <= bad;
          end
        end
        if (last) pass_q <= ~(|bad) & (mism_q == '0);
      end else begin
        idle_q <= idle_q + ONE;
        if (to_hit) begin
          to_q   <= 1'b1;
          pass_q <= 1'b0;
        end
      end
    end
  end

  assign o_busy          = (state == ST_RUN);
  assign o_done          = (state == ST_DONE);
  assign o_pass          = pass_q;
  assign o_timeout       = to_q;
  assign o_cycles        = cycles_q;
  assign o_mismatch_cnt  = mism_q;
  assign o_first_bad_idx = fb_idx_q;
  assign o_first_bad_ch  = fb_ch_q;

endmodule

// File: tb/tb_npu_lockstep_checker.sv
// Scoreboard bench for npu_lockstep_checker: the driver pushes the expected
// pop mask for every vector it expects consumed and the expected run result
// when it starts a run; a negedge monitor pops and compares.
module tb_npu_lockstep_checker;
  import npu_chk_pkg::*;

  localparam int DW   = CHK_DW;
  localparam int NCH  = CHK_NCH;
  localparam int CNTW = CHK_CNTW;

  typedef struct {
    int         cycles;
    int         mism;
    int         fidx;
    logic [1:0] fch;
    logic       pass;
    logic       to;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start;
  logic [CNTW-1:0]   i_num_out;
  logic [NCH-1:0]    i_ch_mask;
  logic [CNTW-1:0]   i_timeout;
  logic              i_gold_valid;
  logic              o_gold_ready;
  logic [DW-1:0]     i_gold_data;
  logic [NCH-1:0]    i_out_rdy;
  logic [NCH*DW-1:0] i_out_data;
  logic [NCH-1:0]    o_out_rd_en;
  logic              o_busy;
  logic              o_done;
  logic              o_pass;
  logic              o_timeout;
  logic [CNTW-1:0]   o_cycles;
  logic [CNTW-1:0]   o_mismatch_cnt;
  logic [CNTW-1:0]   o_first_bad_idx;
  logic [NCH-1:0]    o_first_bad_ch;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] pop_q[$];
  res_t       res_q[$];
  logic [1:0] run_mask = 2'b00;
  int         vec = 0;
  logic       done_seen = 1'b0;

  always #5 clk = ~clk;

  npu_lockstep_checker #(
    .DW   (DW),
    .NCH  (NCH),
    .CNTW (CNTW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_num_out       (i_num_out),
    .i_ch_mask       (i_ch_mask),
    .i_timeout       (i_timeout),
    .i_gold_valid    (i_gold_valid),
    .o_gold_ready    (o_gold_ready),
    .i_gold_data     (i_gold_data),
    .i_out_rdy       (i_out_rdy),
    .i_out_data      (i_out_data),
    .o_out_rd_en     (o_out_rd_en),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_pass          (o_pass),
    .o_timeout       (o_timeout),
    .o_cycles        (o_cycles),
    .o_mismatch_cnt  (o_mismatch_cnt),
    .o_first_bad_idx (o_first_bad_idx),
    .o_first_bad_ch  (o_first_bad_ch)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] gold_of(input int k);
    logic [31:0] w;
    w = 32'h5A5A_0000 + 32'(k) * 32'h0101_0101;
    return {10{w}};
  endfunction

  // Monitor: pops and results are compared against the scoreboard queues.
  always @(negedge clk) begin
    if (o_gold_ready) begin
      if (pop_q.size() == 0) check("unexpected_pop", 64'(o_gold_ready), 64'(0));
      else begin
        check("pop_rd_en", 64'(o_out_rd_en), 64'(pop_q[0]));
        pop_q.delete(0);
      end
    end else begin
      check("rd_en_idle", 64'(o_out_rd_en), 64'(0));
    end
    if (o_done && !done_seen) begin
      done_seen <= 1'b1;
      if (res_q.size() == 0) check("unexpected_done", 64'(o_done), 64'(0));
      else begin
        check("res_cycles",    64'(o_cycles),        64'(res_q[0].cycles));
        check("res_mismatch",  64'(o_mismatch_cnt),  64'(res_q[0].mism));
        check("res_first_idx", 64'(o_first_bad_idx), 64'(res_q[0].fidx));
        check("res_first_ch",  64'(o_first_bad_ch),  64'(res_q[0].fch));
        check("res_pass",      64'(o_pass),          64'(res_q[0].pass));
        check("res_timeout",   64'(o_timeout),       64'(res_q[0].to));
        res_q.delete(0);
      end
    end
    if (i_start) done_seen <= 1'b0;
  end

  task automatic expect_result(input int cyc, input int mism, input int fidx,
                               input logic [1:0] fch, input logic pass, input logic to);
    res_t r;
    r.cycles = cyc; r.mism = mism; r.fidx = fidx; r.fch = fch; r.pass = pass; r.to = to;
    res_q.push_back(r);
  endtask

  task automatic start(input int n, input logic [1:0] m, input int to);
    i_start   = 1'b1;
    i_num_out = CNTW'(n);
    i_ch_mask = m;
    i_timeout = CNTW'(to);
    run_mask  = m;
    vec       = 0;
    @(posedge clk); #1;
    i_start   = 1'b0;
  endtask

  // One cycle of channel/gold stimulus; corrupt[c] inverts channel c's data.
  task automatic step(input logic gv, input logic [1:0] rdy, input logic [1:0] corrupt);
    logic [DW-1:0] g;
    g = gold_of(vec);
    i_gold_valid = gv;
    i_out_rdy    = rdy;
    i_gold_data  = g;
    i_out_data[0  +: DW] = corrupt[0] ? ~g : g;
    i_out_data[DW +: DW] = corrupt[1] ? ~g : g;
    if (gv && ((rdy | ~run_mask) == 2'b11)) begin
      pop_q.push_back(run_mask);
      vec++;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!o_done && n < limit) begin
      step(1'b0, 2'b00, 2'b00);
      n++;
    end
    check("done_reached", 64'(o_done), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_num_out = '0; i_ch_mask = '0; i_timeout = '0;
    i_gold_valid = 1'b0; i_gold_data = '0; i_out_rdy = '0; i_out_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   64'(o_busy),          64'(0));
    check("rst_done",   64'(o_done),          64'(0));
    check("rst_pass",   64'(o_pass),          64'(0));
    check("rst_to",     64'(o_timeout),       64'(0));
    check("rst_cycles", 64'(o_cycles),        64'(0));
    check("rst_mism",   64'(o_mismatch_cnt),  64'(0));
    check("rst_fidx",   64'(o_first_bad_idx), 64'(0));
    check("rst_fch",    64'(o_first_bad_ch),  64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean run.
    expect_result(8, 0, 0, 2'b00, 1'b1, 1'b0);
    start(8, 2'b11, 0);
    check("busy_after_start", 64'(o_busy), 64'(1));
    for (int k = 0; k < 8; k++) step(1'b1, 2'b11, 2'b00);
    wait_done(20);

    // Mismatch capture: channel 1 wrong at vectors 3 and 5.
    expect_result(8, 2, 3, 2'b10, 1'b0, 1'b0);
    start(8, 2'b11, 0);
    for (int k = 0; k < 8; k++) step(1'b1, 2'b11, (k == 3 || k == 5) ? 2'b10 : 2'b00);
    wait_done(20);

    // Stall: channel 0 not ready for 4 cycles mid-run.
    expect_result(12, 0, 0, 2'b00, 1'b1, 1'b0);
    start(8, 2'b11, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) repeat (4) step(1'b1, 2'b10, 2'b00);
      step(1'b1, 2'b11, 2'b00);
    end
    wait_done(20);

    // Masking: channel 1 disabled, never ready, garbage data.
    expect_result(8, 0, 0, 2'b00, 1'b1, 1'b0);
    start(8, 2'b01, 0);
    for (int k = 0; k < 8; k++) step(1'b1, 2'b01, 2'b10);
    wait_done(20);

    // Timeout: gold stops after 3 vectors, limit 5 idle cycles.
    expect_result(8, 0, 0, 2'b00, 1'b0, 1'b1);
    start(8, 2'b11, 5);
    for (int k = 0; k < 3; k++) step(1'b1, 2'b11, 2'b00);
    wait_done(20);

    // Restart at vector 4 (with an earlier mismatch that must be cleared);
    // the restart cycle has gold and channels ready but must not pop.
    start(8, 2'b11, 0);
    for (int k = 0; k < 4; k++) step(1'b1, 2'b11, (k == 1) ? 2'b01 : 2'b00);
    expect_result(8, 0, 0, 2'b00, 1'b1, 1'b0);
    start(8, 2'b11, 0);
    for (int k = 0; k < 8; k++) step(1'b1, 2'b11, 2'b00);
    wait_done(20);

    // Zero-length run.
    i_gold_valid = 1'b0;
    expect_result(0, 0, 0, 2'b00, 1'b1, 1'b0);
    start(0, 2'b11, 0);
    check("zero_done", 64'(o_done), 64'(1));
    check("zero_pass", 64'(o_pass), 64'(1));
    check("zero_busy", 64'(o_busy), 64'(0));
    wait_done(20);

    // Reset mid-run with a mismatch already counted.
    start(8, 2'b11, 0);
    for (int k = 0; k < 3; k++) step(1'b1, 2'b11, (k == 0) ? 2'b10 : 2'b00);
    i_gold_valid = 1'b1; i_out_rdy = 2'b11;
    rst_n = 1'b0;
    #1;
    check("mrst_gold_ready", 64'(o_gold_ready),    64'(0));
    check("mrst_rd_en",      64'(o_out_rd_en),     64'(0));
    check("mrst_busy",       64'(o_busy),          64'(0));
    check("mrst_done",       64'(o_done),          64'(0));
    check("mrst_pass",       64'(o_pass),          64'(0));
    check("mrst_cycles",     64'(o_cycles),        64'(0));
    check("mrst_mism",       64'(o_mismatch_cnt),  64'(0));
    check("mrst_fch",        64'(o_first_bad_ch),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    i_gold_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", 64'(o_busy), 64'(0));

    // Short run after reset.
    expect_result(2, 0, 0, 2'b00, 1'b1, 1'b0);
    start(2, 2'b11, 0);
    for (int k = 0; k < 2; k++) step(1'b1, 2'b11, 2'b00);
    wait_done(20);

    repeat (3) step(1'b0, 2'b00, 2'b00);
    check("pop_q_empty", 64'(pop_q.size()), 64'(0));
    check("res_q_empty", 64'(res_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
